dft_dump_collector: RTL

- Sits directly downstream of dft_top. Drives its DFT-side handshake (dft_val_op / dft_commit_ack) to request a scan dump.
- Captures every 32-bit word presented on dft_out while dft_out_strobe is high into a local FIFO.
- Host logic drains the FIFO through a simple read port. One start pulse produces one complete dump transaction.

---
 rtl/dft_dump_collector.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/dft_dump_collector.sv
// Scan-dump collector: requests a dump from dft_top, buffers every strobed word in
// a FIFO and lets host logic drain it through a registered single-word pop port.
module dft_dump_collector #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_cnt,
    output logic              dft_val_op,
    input  logic              dft_op_ack,
    input  logic [31:0]       dft_out,
    input  logic              dft_out_strobe,
    input  logic              dft_op_commit,
    output logic              dft_commit_ack,
    input  logic              rd_en,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic              empty
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_ACK     = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);

    logic [2:0]        state_r;
    logic [2:0]        state_next_s;
    logic              ack_first_r;
    logic [31:0]       mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   cnt_r;
    logic [ADDR_W:0]   cnt_next_s;
    logic              busy_r;
    logic              done_r;
    logic              val_op_r;
    logic              commit_ack_r;
    logic              overflow_r;
    logic              empty_r;
    logic [31:0]       rd_data_r;
    logic              rd_valid_r;

    logic              flush_s;
    logic              accept_s;
    logic              full_s;
    logic              wr_s;
    logic              drop_s;
    logic              rd_s;

    // Next-state decode of the dump handshake
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dft_op_ack) begin
                    state_next_s = ST_CAPTURE;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_CAPTURE: begin
                if (dft_op_commit) begin
                    state_next_s = ST_ACK;
                end else begin
                    state_next_s = ST_CAPTURE;
                end
            end
            ST_ACK: begin
                if (!dft_op_commit) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ACK;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FIFO write/pop qualification; a pop never frees room for a same-cycle write
    always_comb begin
        flush_s  = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && start;
        accept_s = (state_r == ST_REQ) || (state_r == ST_CAPTURE) ||
                   ((state_r == ST_ACK) && ack_first_r);
        full_s   = (cnt_r == CNT_FULL);
        wr_s     = accept_s && dft_out_strobe && !full_s;
        drop_s   = accept_s && dft_out_strobe && full_s;
        rd_s     = rd_en && (cnt_r != CNT_ZERO);
    end

    // Occupancy update; flush can only coincide with a pop, never with a write
    always_comb begin
        cnt_next_s = cnt_r;
        if (flush_s) begin
            cnt_next_s = CNT_ZERO;
        end else begin
            case ({wr_s, rd_s})
                2'b10:   cnt_next_s = cnt_r + CNT_ONE;
                2'b01:   cnt_next_s = cnt_r - CNT_ONE;
                default: cnt_next_s = cnt_r;
            endcase
        end
    end

    // FSM state and registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            ack_first_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            val_op_r     <= 1'b0;
            commit_ack_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            ack_first_r  <= (state_next_s == ST_ACK) && (state_r != ST_ACK);
            busy_r       <= (state_next_s == ST_REQ) || (state_next_s == ST_CAPTURE) ||
                            (state_next_s == ST_ACK);
            done_r       <= (state_next_s == ST_DONE);
            val_op_r     <= (state_next_s == ST_REQ);
            commit_ack_r <= (state_next_s == ST_ACK);
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            cnt_r      <= CNT_ZERO;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_next_s;
            empty_r <= (cnt_next_s == CNT_ZERO);
            if (flush_s) begin
                wr_ptr_r   <= PTR_ZERO;
                rd_ptr_r   <= PTR_ZERO;
                overflow_r <= 1'b0;
            end else begin
                if (wr_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (rd_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
                if (drop_s) begin
                    overflow_r <= 1'b1;
                end
            end
        end
    end

    // Storage array; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= dft_out;
        end
    end

    // Registered pop port; rd_data holds its last value when nothing is popped
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r  <= 32'h0000_0000;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_s;
            if (rd_s) begin
                rd_data_r <= mem_r[rd_ptr_r];
            end
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign overflow       = overflow_r;
    assign word_cnt       = cnt_r;
    assign dft_val_op     = val_op_r;
    assign dft_commit_ack = commit_ack_r;
    assign rd_data        = rd_data_r;
    assign rd_valid       = rd_valid_r;
    assign empty          = empty_r;

endmodule
